bram_tone_seq_ctrl: RTL
=======================

// Module: bram_tone_seq_ctrl
// PURPOSE
//  Second-generation tone-table controller for a true dual-port BRAM. Loads LOAD_LEN samples from the
//  UART unpacker (two samples per beat on ports A/B), then plays the table back on both ports.
//  Playback uses a programmable step (frequency tuning) and a programmable A-to-B phase offset.
//  Sits between the UART 12-bit unpacker and the tone BRAM; playback addresses feed the DAC path.
// PARAMETERS
//  DATA_W    12   sample width
//  ADDR_W    10   BRAM address width
//  LOAD_LEN  512  samples per table; even, 2..2^ADDR_W; beats per load = LOAD_LEN/2
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       asynchronous reset, active low
//  wr_valid       in   1       one beat of two samples valid this cycle
//  wr_data_a      in   DATA_W  even-address sample
//  wr_data_b      in   DATA_W  odd-address sample
//  load_start     in   1       pulse: (re)start table load
//  play_en        in   1       level: playback request
//  step_i         in   ADDR_W  playback address increment per cycle
//  phase_off_i    in   ADDR_W  port-B address offset from port A during playback
//  ram_addr_a     out  ADDR_W  BRAM port A address
//  ram_addr_b     out  ADDR_W  BRAM port B address
//  ram_wr_data_a  out  DATA_W  BRAM port A write data
//  ram_wr_data_b  out  DATA_W  BRAM port B write data
//  bram_en        out  1       BRAM enable, both ports
//  bram_wea       out  1       1 = write, 0 = read, both ports
//  load_done      out  1       sticky: full table written
//  playing        out  1       FSM in PLAY
//  wr_err         out  1       1-cycle pulse: wr_valid outside LOAD
//  cfg_err        out  1       level: step_i or phase_off_i >= LOAD_LEN while in PLAY
// BEHAVIOUR
//  - Reset values: FSM=IDLE, ram_addr_a=0, ram_addr_b=1, wr data=0, en=0, wea=0, flags=0. All outputs registered.
//  - FSM states: IDLE, LOAD, DONE, PLAY.
//  - load_start in any state -> LOAD next cycle. Clears load_done, beat count and playback accumulator.
//    load_start has priority over a same-cycle wr_valid; that beat is dropped without wr_err.
//  - Writes in LOAD: for beat k, wr_valid in cycle n drives in cycle n+1: addr_a=2k, addr_b=2k+1,
//    data registered from the inputs, en=1, wea=1. Cycles without wr_valid drive en=0.
//  - Completion: after beat LOAD_LEN/2-1 is issued -> DONE; load_done=1 from the same cycle as that
//    write. In DONE: en=0, wea=0.
//  - wr_valid in IDLE/DONE/PLAY: ignored; wr_err pulses for 1 cycle (1-cycle latency).
//  - DONE & play_en=1 -> PLAY; accumulator acc starts at 0.
//  - In PLAY, each cycle: en=1, wea=0, addr_a=acc, addr_b=(acc+off) mod LOAD_LEN,
//    then acc <= (acc+step) mod LOAD_LEN.
//  - Modulo: conditional subtract of LOAD_LEN on an ADDR_W+1-bit sum; exact because both operands < LOAD_LEN.
//  - step_i/phase_off_i >= LOAD_LEN: the value is treated as 0 and cfg_err=1 while the condition holds.
//  - Inputs are sampled every cycle, so a step change takes effect on the next increment.
//  - play_en=0 in PLAY -> DONE next cycle (en=0). Re-entry to PLAY restarts acc at 0.
//  - play_en in IDLE/LOAD: ignored; no playback before load_done.
//  - Reset mid-load or mid-play: immediate return to reset values; the table is assumed invalid.
// TESTING
//  T1 reset -> all outputs at reset values; play_en=1 with no load -> en stays 0
//  T2 load_start, 256 beats (a=2k, b=2k+1 values) -> writes addr 0..511 in pairs; load_done=1 at beat 255
//  T3 gapped wr_valid (1 in 3 cycles) -> addresses advance only on valid beats; en=0 in gaps
//  T4 play, step=3, off=128 -> addr_a 0,3,...,510,1 (wrap); addr_b = addr_a+128 mod 512; wea=0
//  T5 wr_valid in DONE -> wr_err pulse, no write; load_start with same-cycle wr_valid -> beat dropped, count=0
//  T6 step_i=600 -> cfg_err=1 and addr_a frozen; reset asserted mid-load -> IDLE, load_done=0

Source files
------------

// File: rtl/bram_tone_seq_ctrl.sv
// Tone-table controller for a true dual-port BRAM.
// Loads sample pairs from the UART unpacker, then plays the table back with a step and a phase offset.
module bram_tone_seq_ctrl #(
   parameter int DATA_W   = 12,
   parameter int ADDR_W   = 10,
   parameter int LOAD_LEN = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data_a,
   input  logic [DATA_W-1:0] wr_data_b,
   input  logic              load_start,
   input  logic              play_en,
   input  logic [ADDR_W-1:0] step_i,
   input  logic [ADDR_W-1:0] phase_off_i,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic [DATA_W-1:0] ram_wr_data_a,
   output logic [DATA_W-1:0] ram_wr_data_b,
   output logic              bram_en,
   output logic              bram_wea,
   output logic              load_done,
   output logic              playing,
   output logic              wr_err,
   output logic              cfg_err
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, PLAY} state_t;

   localparam logic [ADDR_W:0]   LEN       = (ADDR_W+1)'(LOAD_LEN);
   localparam logic [ADDR_W-2:0] LAST_BEAT = (ADDR_W-1)'(LOAD_LEN/2 - 1);

   state_t            state;
   logic [ADDR_W-2:0] beat;
   logic [ADDR_W-1:0] acc;

   logic              step_bad;
   logic              off_bad;
   logic [ADDR_W-1:0] step_eff;
   logic [ADDR_W-1:0] off_eff;
   logic [ADDR_W:0]   sum_step;
   logic [ADDR_W:0]   sum_off;
   logic [ADDR_W-1:0] acc_next;
   logic [ADDR_W-1:0] addr_b_next;

   // Out-of-range config reads as zero, so both addends stay below LEN
   // and a single conditional subtract is an exact modulo.
   always_comb begin
      step_bad    = {1'b0, step_i} >= LEN;
      off_bad     = {1'b0, phase_off_i} >= LEN;
      step_eff    = step_bad ? '0 : step_i;
      off_eff     = off_bad ? '0 : phase_off_i;
      sum_step    = {1'b0, acc} + {1'b0, step_eff};
      sum_off     = {1'b0, acc} + {1'b0, off_eff};
      acc_next    = (sum_step >= LEN) ? ADDR_W'(sum_step - LEN)
                                      : sum_step[ADDR_W-1:0];
      addr_b_next = (sum_off >= LEN) ? ADDR_W'(sum_off - LEN)
                                     : sum_off[ADDR_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         beat          <= '0;
         acc           <= '0;
         ram_addr_a    <= '0;
         ram_addr_b    <= ADDR_W'(1);
         ram_wr_data_a <= '0;
         ram_wr_data_b <= '0;
         bram_en       <= 1'b0;
         bram_wea      <= 1'b0;
         load_done     <= 1'b0;
         playing       <= 1'b0;
         wr_err        <= 1'b0;
         cfg_err       <= 1'b0;
      end else begin
         bram_en  <= 1'b0;
         bram_wea <= 1'b0;
         wr_err   <= 1'b0;
         cfg_err  <= 1'b0;
         if (load_start) begin
            state     <= LOAD;
            beat      <= '0;
            acc       <= '0;
            load_done <= 1'b0;
            playing   <= 1'b0;
         end else begin
            wr_err <= wr_valid && (state != LOAD);
            unique case (state)
               IDLE: ;
               LOAD: begin
                  if (wr_valid) begin
                     ram_addr_a    <= {beat, 1'b0};
                     ram_addr_b    <= {beat, 1'b1};
                     ram_wr_data_a <= wr_data_a;
                     ram_wr_data_b <= wr_data_b;
                     bram_en       <= 1'b1;
                     bram_wea      <= 1'b1;
                     beat          <= beat + 1'b1;
                     if (beat == LAST_BEAT) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  if (play_en) begin
                     state   <= PLAY;
                     acc     <= '0;
                     playing <= 1'b1;
                  end
               end
               PLAY: begin
                  if (!play_en) begin
                     state   <= DONE;
                     playing <= 1'b0;
                  end else begin
                     ram_addr_a <= acc;
                     ram_addr_b <= addr_b_next;
                     bram_en    <= 1'b1;
                     acc        <= acc_next;
                     cfg_err    <= step_bad | off_bad;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
